// File: rtl/acc_operand_stage.sv
// ---------------------------------------------------------------------------
// acc_operand_stage
//
// Operand-fetch stage for a small accumulator machine. Holds an 8 x 8-bit
// register file plus an 8-bit accumulator. When an instruction is captured,
// acc_ctrl selects which storage element feeds each operand. The selected
// operands and flags are registered into a one-entry output holding slot.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer keeps its payload stable while
// valid is high and ready is low. in_ready = !out_valid || out_ready, so the
// slot refills in the same cycle it drains and runs back-to-back at full rate.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake for the decoded instruction
//   acc_ctrl[2:0]       operand-source code from the accumulator decoder
//   ra1, ra2 [2:0]      register-file read addresses
//   rf_we/rf_wa/rf_wd   register-file write port (rf[0] is writable)
//   acc_we/acc_wd       accumulator write port
//   rd1, rd2 [7:0]      registered operands
//   mov                 registered flag: accumulator-to-register move
//   ctrl_err            registered flag: acc_ctrl was an undefined code
//   out_valid/out_ready downstream handshake for the held instruction
//
// Build option
//   ACC_OPERAND_BYPASS_EN  when defined, a capture on the same edge as a
//                          write to the addressed register (or accumulator)
//                          takes the new write data. When undefined, the
//                          capture sees the pre-write value.
// ---------------------------------------------------------------------------
module acc_operand_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] acc_ctrl,
  input  logic [2:0] ra1,
  input  logic [2:0] ra2,
  input  logic       rf_we,
  input  logic [2:0] rf_wa,
  input  logic [7:0] rf_wd,
  input  logic       acc_we,
  input  logic [7:0] acc_wd,
  output logic [7:0] rd1,
  output logic [7:0] rd2,
  output logic       mov,
  output logic       ctrl_err,
  output logic       out_valid,
  input  logic       out_ready
);

  // Operand-source codes. Anything not listed is undefined and is decoded
  // as a plain register/register read with ctrl_err raised.
  localparam logic [2:0] CTRL_RR  = 3'b000;
  localparam logic [2:0] CTRL_RA  = 3'b001;
  localparam logic [2:0] CTRL_AR  = 3'b010;
  localparam logic [2:0] CTRL_MOV = 3'b101;

  logic [7:0] rf [0:7];
  logic [7:0] acc;

  logic [7:0] rf_rd1_val;
  logic [7:0] rf_rd2_val;
  logic [7:0] acc_val;

  logic [7:0] sel_rd1;
  logic [7:0] sel_rd2;
  logic       sel_mov;
  logic       sel_err;

  logic       capture;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  // Storage read ports, with optional same-edge write forwarding.
  always_comb begin
    rf_rd1_val = rf[ra1];
    rf_rd2_val = rf[ra2];
    acc_val    = acc;
`ifdef ACC_OPERAND_BYPASS_EN
    if (rf_we && (rf_wa == ra1)) rf_rd1_val = rf_wd;
    if (rf_we && (rf_wa == ra2)) rf_rd2_val = rf_wd;
    if (acc_we)                  acc_val    = acc_wd;
`endif
  end

  // Operand-source decode.
  always_comb begin
    sel_rd1 = rf_rd1_val;
    sel_rd2 = rf_rd2_val;
    sel_mov = 1'b0;
    sel_err = 1'b0;
    case (acc_ctrl)
      CTRL_RR: begin
        sel_rd1 = rf_rd1_val;
        sel_rd2 = rf_rd2_val;
      end
      CTRL_RA: begin
        sel_rd1 = rf_rd1_val;
        sel_rd2 = acc_val;
      end
      CTRL_AR: begin
        sel_rd1 = acc_val;
        sel_rd2 = rf_rd2_val;
      end
      CTRL_MOV: begin
        sel_rd1 = rf_rd1_val;
        sel_rd2 = acc_val;
        sel_mov = 1'b1;
      end
      default: begin
        sel_rd1 = rf_rd1_val;
        sel_rd2 = rf_rd2_val;
        sel_err = 1'b1;
      end
    endcase
  end

  // Register file and accumulator. Writes ignore the handshake entirely;
  // reset takes priority over any write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      acc <= 8'h00;
    end else begin
      if (rf_we)  rf[rf_wa] <= rf_wd;
      if (acc_we) acc       <= acc_wd;
    end
  end

  // Output holding slot. Data only changes on capture, so later storage
  // writes never disturb an instruction that is waiting for out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      rd1       <= 8'h00;
      rd2       <= 8'h00;
      mov       <= 1'b0;
      ctrl_err  <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      rd1       <= sel_rd1;
      rd2       <= sel_rd2;
      mov       <= sel_mov;
      ctrl_err  <= sel_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_acc_operand_stage
//
// Directed bench for acc_operand_stage. Inputs are driven 1 ns after the
// rising edge and outputs sampled 1 ns after the following rising edge.
// Expected values are hand-computed from the register contents each test
// writes. The same-edge forwarding expectations follow
// ACC_OPERAND_BYPASS_EN, which is passed to both bench and design.
// ---------------------------------------------------------------------------
module tb_acc_operand_stage;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] acc_ctrl;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic       rf_we;
  logic [2:0] rf_wa;
  logic [7:0] rf_wd;
  logic       acc_we;
  logic [7:0] acc_wd;
  logic [7:0] rd1;
  logic [7:0] rd2;
  logic       mov;
  logic       ctrl_err;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  acc_operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_ctrl  (acc_ctrl),
    .ra1       (ra1),
    .ra2       (ra2),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .acc_we    (acc_we),
    .acc_wd    (acc_wd),
    .rd1       (rd1),
    .rd2       (rd2),
    .mov       (mov),
    .ctrl_err  (ctrl_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    acc_ctrl = 3'b000;
    ra1      = 3'd0;
    ra2      = 3'd0;
    rf_we    = 1'b0;
    rf_wa    = 3'd0;
    rf_wd    = 8'h00;
    acc_we   = 1'b0;
    acc_wd   = 8'h00;
  endtask

  task automatic drive_instr(input logic [2:0] c, input logic [2:0] a1,
                             input logic [2:0] a2);
    in_valid = 1'b1;
    acc_ctrl = c;
    ra1      = a1;
    ra2      = a2;
  endtask

  task automatic write_rf(input logic [2:0] wa, input logic [7:0] wd);
    rf_we = 1'b1;
    rf_wa = wa;
    rf_wd = wd;
  endtask

  task automatic write_acc(input logic [7:0] wd);
    acc_we = 1'b1;
    acc_wd = wd;
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    checks++;
    if ({rd1, rd2, mov, ctrl_err} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs got rd1=%h rd2=%h mov=%b err=%b exp all 0",
                         rd1, rd2, mov, ctrl_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_basic_read();
    write_rf(3'd3, 8'h5A);
    cycle();
    idle_inputs();
    drive_instr(3'b000, 3'd3, 3'd0);
    cycle();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid got %b exp 1", out_valid);
    end
    checks++;
    if (rd1 !== 8'h5A || rd2 !== 8'h00 || mov !== 1'b0 || ctrl_err !== 1'b0) begin
      errors++; $display("FAIL basic_data got rd1=%h rd2=%h mov=%b err=%b exp 5a 00 0 0",
                         rd1, rd2, mov, ctrl_err);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_acc_sources();
    // acc=0x11, rf[2]=0x22; rf[3]=0x5A from the previous test
    write_acc(8'h11);
    write_rf(3'd2, 8'h22);
    cycle();
    idle_inputs();
    drive_instr(3'b010, 3'd3, 3'd2);
    cycle();
    checks++;
    if (rd1 !== 8'h11 || rd2 !== 8'h22 || mov !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL code010 got rd1=%h rd2=%h mov=%b v=%b exp 11 22 0 1",
                         rd1, rd2, mov, out_valid);
    end
    drive_instr(3'b101, 3'd2, 3'd0);
    cycle();
    checks++;
    if (rd1 !== 8'h22 || rd2 !== 8'h11 || mov !== 1'b1 || ctrl_err !== 1'b0) begin
      errors++; $display("FAIL code101 got rd1=%h rd2=%h mov=%b err=%b exp 22 11 1 0",
                         rd1, rd2, mov, ctrl_err);
    end
    drive_instr(3'b001, 3'd3, 3'd2);
    cycle();
    idle_inputs();
    checks++;
    if (rd1 !== 8'h5A || rd2 !== 8'h11 || mov !== 1'b0) begin
      errors++; $display("FAIL code001 got rd1=%h rd2=%h mov=%b exp 5a 11 0",
                         rd1, rd2, mov);
    end
    cycle();
  endtask

  task automatic test_ctrl_err();
    logic [2:0] bad [4];
    bad[0] = 3'b011; bad[1] = 3'b100; bad[2] = 3'b110; bad[3] = 3'b111;
    for (int i = 0; i < 4; i++) begin
      drive_instr(bad[i], 3'd3, 3'd2);
      cycle();
      checks++;
      if (rd1 !== 8'h5A || rd2 !== 8'h22 || mov !== 1'b0 || ctrl_err !== 1'b1) begin
        errors++; $display("FAIL ctrl_err_%b got rd1=%h rd2=%h mov=%b err=%b exp 5a 22 0 1",
                           bad[i], rd1, rd2, mov, ctrl_err);
      end
    end
    drive_instr(3'b000, 3'd2, 3'd3);
    cycle();
    idle_inputs();
    checks++;
    if (rd1 !== 8'h22 || rd2 !== 8'h5A || ctrl_err !== 1'b0) begin
      errors++; $display("FAIL ctrl_err_clear got rd1=%h rd2=%h err=%b exp 22 5a 0",
                         rd1, rd2, ctrl_err);
    end
    cycle();
  endtask

  task automatic test_stall();
    drive_instr(3'b000, 3'd3, 3'd2);   // A: 5a / 22
    cycle();
    out_ready = 1'b0;
    drive_instr(3'b001, 3'd2, 3'd0);   // B: 22 / 11, waits upstream
    write_rf(3'd3, 8'h77);             // must not disturb held A
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready_%0d got %b exp 0", i, in_ready);
      end
      cycle();
      rf_we = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || rd1 !== 8'h5A || rd2 !== 8'h22 || mov !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b rd1=%h rd2=%h mov=%b exp 1 5a 22 0",
                           i, out_valid, rd1, rd2, mov);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || rd1 !== 8'h22 || rd2 !== 8'h11) begin
      errors++; $display("FAIL stall_no_bubble got v=%b rd1=%h rd2=%h exp 1 22 11",
                         out_valid, rd1, rd2);
    end
    drive_instr(3'b000, 3'd3, 3'd3);   // C: sees rf[3]=77
    cycle();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || rd1 !== 8'h77 || rd2 !== 8'h77) begin
      errors++; $display("FAIL back_to_back got v=%b rd1=%h rd2=%h exp 1 77 77",
                         out_valid, rd1, rd2);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL back_to_back_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp_rf;
    logic [7:0] exp_acc;
`ifdef ACC_OPERAND_BYPASS_EN
    exp_rf  = 8'h99;
    exp_acc = 8'hAB;
`else
    exp_rf  = 8'h01;
    exp_acc = 8'h11;
`endif
    write_rf(3'd4, 8'h01);
    cycle();
    idle_inputs();
    write_rf(3'd4, 8'h99);
    drive_instr(3'b000, 3'd4, 3'd2);
    cycle();
    idle_inputs();
    checks++;
    if (rd1 !== exp_rf || rd2 !== 8'h22) begin
      errors++; $display("FAIL bypass_rf got rd1=%h rd2=%h exp %h 22", rd1, rd2, exp_rf);
    end
    write_acc(8'hAB);
    drive_instr(3'b001, 3'd4, 3'd0);
    cycle();
    idle_inputs();
    checks++;
    if (rd1 !== 8'h99 || rd2 !== exp_acc) begin
      errors++; $display("FAIL bypass_acc got rd1=%h rd2=%h exp 99 %h", rd1, rd2, exp_acc);
    end
    drive_instr(3'b010, 3'd0, 3'd4);
    cycle();
    idle_inputs();
    checks++;
    if (rd1 !== 8'hAB || rd2 !== 8'h99) begin
      errors++; $display("FAIL bypass_after got rd1=%h rd2=%h exp ab 99", rd1, rd2);
    end
    cycle();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive_instr(3'b101, 3'd4, 3'd0);   // 99 / ab, mov
    cycle();
    checks++;
    if (out_valid !== 1'b1 || rd1 !== 8'h99 || mov !== 1'b1) begin
      errors++; $display("FAIL midflight_held got v=%b rd1=%h mov=%b exp 1 99 1",
                         out_valid, rd1, mov);
    end
    reset = 1'b1;                      // with capture and writes pending
    write_rf(3'd5, 8'hEE);
    write_acc(8'hCC);
    drive_instr(3'b111, 3'd4, 3'd4);
    cycle();
    reset = 1'b0;
    idle_inputs();
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || {rd1, rd2, mov, ctrl_err} !== 18'h0) begin
      errors++; $display("FAIL midflight_reset got v=%b rd1=%h rd2=%h mov=%b err=%b exp all 0",
                         out_valid, rd1, rd2, mov, ctrl_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midflight_in_ready got %b exp 1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      drive_instr(3'b001, 3'(i), 3'(7 - i));
      cycle();
      checks++;
      if (out_valid !== 1'b1 || rd1 !== 8'h00 || rd2 !== 8'h00) begin
        errors++; $display("FAIL storage_clear_%0d got v=%b rd1=%h rd2=%h exp 1 00 00",
                           i, out_valid, rd1, rd2);
      end
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_acc_sources();
    test_ctrl_err();
    test_stall();
    test_bypass();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_operand_stage.md
ACC_OPERAND_STAGE -- requirements
Module: acc_operand_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  decoded instruction present.
REQ-004 SHALL have port: in_ready  output  1  stage can accept an instruction this cycle.
REQ-005 SHALL have port: acc_ctrl  input  3  operand-source model from the accumulator decoder.
REQ-006 SHALL have port: ra1  input  3  register-file read address, operand 1.
REQ-007 SHALL have port: ra2  input  3  register-file read address, operand 2.
REQ-008 SHALL have port: rf_we, rf_wa[2:0], rf_wd[7:0]  input  1/3/8  register-file write port.
REQ-009 SHALL have port: acc_we, acc_wd[7:0]  input  1/8  accumulator write port.
REQ-010 SHALL have port: rd1, rd2  output  8 each  registered operands.
REQ-011 SHALL have port: mov  output  1  registered flag; the held instruction is acc-to-register move.
REQ-012 SHALL have port: ctrl_err  output  1  registered flag; acc_ctrl was an undefined code.
REQ-013 SHALL have port: out_valid  output  1  rd1/rd2/mov/ctrl_err hold a valid instruction.
REQ-014 SHALL have port: out_ready  input  1  downstream accepts the held instruction.

Function
REQ-015 SHALL contain eight 8-bit registers rf[0..7] and one 8-bit accumulator acc; all writable, including rf[0].
REQ-016 SHALL write rf[rf_wa] <= rf_wd when rf_we, and acc <= acc_wd when acc_we, each edge, independent of handshake state; both may occur in the same cycle.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-018 SHALL capture an instruction on an edge where in_valid && in_ready; one-cycle latency to out_valid.
REQ-019 SHALL select operands on capture: code 000 -> rd1=rf[ra1], rd2=rf[ra2]; 001 -> rd1=rf[ra1], rd2=acc; 010 -> rd1=acc, rd2=rf[ra2]; 101 -> rd1=rf[ra1], rd2=acc, mov=1.
REQ-020 SHALL treat codes 011, 100, 110, 111 as code 000 and set ctrl_err=1 for that instruction; mov=0, ctrl_err=0 otherwise.
REQ-021 SHALL, with out_valid=1 and out_ready=0, hold rd1, rd2, mov, ctrl_err stable and keep out_valid=1; later register/acc writes SHALL NOT alter held outputs.
REQ-022 SHALL, with out_valid=1, out_ready=1, in_valid=0, clear out_valid next cycle.
REQ-023 SHALL, with out_valid=1, out_ready=1, in_valid=1, replace held outputs with the new instruction, out_valid staying 1 (back-to-back, full throughput).
REQ-024 SHALL leave output data undefined-but-stable when out_valid=0; only out_valid is meaningful then.

Reset
REQ-025 SHALL, on an edge with reset=1, set out_valid=0, rd1=0, rd2=0, mov=0, ctrl_err=0, acc=0, rf[0..7]=0.
REQ-026 SHALL let reset win over any simultaneous capture or write; an in-flight held instruction is discarded.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL support macro ACC_OPERAND_BYPASS_EN.
REQ-029 SHALL, with ACC_OPERAND_BYPASS_EN defined, capture same-edge write data: read of rf[x] with rf_we && rf_wa==x returns rf_wd; acc read with acc_we returns acc_wd.
REQ-030 SHALL, with ACC_OPERAND_BYPASS_EN undefined, capture pre-write values in that case (write visible from the following capture).

Verification
REQ-031 SHALL cover: reset, then rf_we wa=3 wd=0x5A, next capture code 000 ra1=3 ra2=0 -> rd1=0x5A, rd2=0x00, out_valid=1 one cycle after capture.
REQ-032 SHALL cover: acc=0x11, rf[2]=0x22, capture code 010 ra2=2 -> rd1=0x11, rd2=0x22; code 101 ra1=2 -> rd1=0x22, rd2=0x11, mov=1.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> next instruction captured with no bubble.
REQ-034 SHALL cover: same cycle rf_we wa=4 wd=0x99 and capture ra1=4 (old 0x01) -> rd1=0x99 with ACC_OPERAND_BYPASS_EN, 0x01 without.
REQ-035 SHALL cover: capture code 111 -> ctrl_err=1, rd1=rf[ra1], rd2=rf[ra2], mov=0.
REQ-036 SHALL cover: reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, all outputs and storage 0.
